// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: memory ops, FSM states, write-enable constants.
// Also holds the misalignment predicate used when MEM_MISALIGN_TRAP_EN is defined.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO          = '0;

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and load sign/zero extension.
module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = load_raw[{addr_lo, 3'b000} +: 8];
        half_sel  = load_raw[{addr_lo[1], 4'b0000} +: 16];
        be        = 4'b0000;
        wdata     = store_data;
        load_data = load_raw;
        case (op)
            MEM_LB: begin
                be        = 4'b1111;
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            MEM_LBU: begin
                be        = 4'b1111;
                load_data = {24'd0, byte_sel};
            end
            MEM_LH: begin
                be        = 4'b1111;
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            MEM_LHU: begin
                be        = 4'b1111;
                load_data = {16'd0, half_sel};
            end
            MEM_LW: be = 4'b1111;
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_SH: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            MEM_SW:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs a req/gnt/rvalid data-bus transaction and registers writeback.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_o and suppresses the bus access for misaligned LH/LHU/SH/LW/SW.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
)(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  stall_o,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [3:0]            mem_op_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_WIDTH-1:0] dbus_addr_o,
    output logic [3:0]            dbus_be_o,
    output logic [DATA_WIDTH-1:0] dbus_wdata_o,
    input  logic                  dbus_gnt_i,
    input  logic                  dbus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dbus_rdata_i,
    output logic                  wb_valid_o,
    output logic                  wb_reg_we_o,
    output logic [4:0]            wb_reg_waddr_o,
    output logic [DATA_WIDTH-1:0] wb_reg_wdata_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    state_e                state;
    mem_op_e               op_in;
    mem_op_e               lat_op;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [4:0]            lat_waddr;
    logic                  lat_reg_we;
    logic                  lat_mem_we;
    logic                  is_req;
    logic [3:0]            align_be;
    logic [31:0]           align_wdata;
    logic [31:0]           load_data;

    assign op_in = mem_op_e'(mem_op_i);

    mem_lsu_align u_align (
        .op         (lat_op),
        .addr_lo    (lat_addr[1:0]),
        .store_data (lat_data),
        .load_raw   (dbus_rdata_i),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (load_data)
    );

    // Bus outputs are derived from the latched request, so they stay stable for the whole REQ phase.
    assign is_req       = (state == REQ);
    assign ready_o      = (state == IDLE);
    assign stall_o      = ~ready_o;
    assign dbus_req_o   = is_req;
    assign dbus_we_o    = is_req && (lat_mem_we == WRITE_ENABLE);
    assign dbus_addr_o  = is_req ? {lat_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dbus_be_o    = is_req ? align_be : 4'b0000;
    assign dbus_wdata_o = is_req ? align_wdata : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            lat_op         <= MEM_NOP;
            lat_addr       <= '0;
            lat_data       <= '0;
            lat_waddr      <= '0;
            lat_reg_we     <= WRITE_DISABLE;
            lat_mem_we     <= WRITE_DISABLE;
            wb_valid_o     <= 1'b0;
            wb_reg_we_o    <= WRITE_DISABLE;
            wb_reg_waddr_o <= '0;
            wb_reg_wdata_o <= ZERO;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o     <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (op_in == MEM_NOP) begin
                            wb_valid_o     <= 1'b1;
                            wb_reg_we_o    <= reg_we_i;
                            wb_reg_waddr_o <= reg_waddr_i;
                            wb_reg_wdata_o <= reg_wdata_i;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (is_misaligned(op_in, mem_addr_i[1:0])) begin
                            wb_valid_o     <= 1'b1;
                            wb_reg_we_o    <= WRITE_DISABLE;
                            wb_reg_waddr_o <= reg_waddr_i;
                            wb_reg_wdata_o <= ZERO;
                            misalign_o     <= 1'b1;
                        end
`endif
                        else begin
                            lat_op     <= op_in;
                            lat_addr   <= mem_addr_i;
                            lat_data   <= mem_data_i;
                            lat_waddr  <= reg_waddr_i;
                            lat_reg_we <= reg_we_i;
                            lat_mem_we <= mem_we_i;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) begin
                        if (lat_mem_we == WRITE_ENABLE) begin
                            state          <= IDLE;
                            wb_valid_o     <= 1'b1;
                            wb_reg_we_o    <= WRITE_DISABLE;
                            wb_reg_waddr_o <= lat_waddr;
                            wb_reg_wdata_o <= ZERO;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (dbus_rvalid_i) begin
                        state          <= IDLE;
                        wb_valid_o     <= 1'b1;
                        wb_reg_we_o    <= lat_reg_we;
                        wb_reg_waddr_o <= lat_waddr;
                        wb_reg_wdata_o <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized mix against a behavioural model.
// Exercises misalign_o as well when MEM_MISALIGN_TRAP_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready, stall;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic [3:0]  mem_op = '0;
    logic [4:0]  reg_waddr = '0;
    logic        reg_we = 1'b0;
    logic [31:0] reg_wdata = '0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        wb_valid, wb_reg_we;
    logic [4:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .valid_i        (valid),
        .ready_o        (ready),
        .stall_o        (stall),
        .mem_we_i       (mem_we),
        .mem_addr_i     (mem_addr),
        .mem_data_i     (mem_data),
        .mem_op_i       (mem_op),
        .reg_waddr_i    (reg_waddr),
        .reg_we_i       (reg_we),
        .reg_wdata_i    (reg_wdata),
        .dbus_req_o     (dbus_req),
        .dbus_we_o      (dbus_we),
        .dbus_addr_o    (dbus_addr),
        .dbus_be_o      (dbus_be),
        .dbus_wdata_o   (dbus_wdata),
        .dbus_gnt_i     (dbus_gnt),
        .dbus_rvalid_i  (dbus_rvalid),
        .dbus_rdata_i   (dbus_rdata),
        .wb_valid_o     (wb_valid),
        .wb_reg_we_o    (wb_reg_we),
        .wb_reg_waddr_o (wb_reg_waddr),
        .wb_reg_wdata_o (wb_reg_wdata)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o     (misalign)
`endif
    );

    // Behavioural reference: op codes 0..8 = NOP, LB, LH, LW, LBU, LHU, SB, SH, SW.
    function automatic logic [3:0] m_be(input int op, input int a);
        if (op == 0) return 4'd0;
        if (op == 6) return 4'(1 << a);
        if (op == 7) return 4'(3 << (a & 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] d);
        if (op == 6) return (d & 32'hFF) * 32'h01010101;
        if (op == 7) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int op, input int a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            1:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4:       return b;
            2:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
            5:       return h;
            default: return rd;
        endcase
    endfunction

    function automatic bit m_trap(input int op, input int a);
`ifdef MEM_MISALIGN_TRAP_EN
        return ((op == 2 || op == 5 || op == 7) && (a % 2 == 1)) ||
               ((op == 3 || op == 8) && (a != 0));
`else
        return (op < 0) && (a < 0);
`endif
    endfunction

    // Observations collected by run_mem for the calling test to compare.
    bit          obs_mem, obs_stable, obs_stall_ok, obs_wait_ok, obs_ready_first, obs_ready_after;
    bit          obs_mis, obs_mis_next;
    int          obs_pulses;
    logic        obs_bus_we, obs_wb_we;
    logic [31:0] obs_addr, obs_wdata, obs_wb_wdata;
    logic [3:0]  obs_be;
    logic [4:0]  obs_wb_waddr;

    task automatic capture_wb();
        obs_wb_we    = wb_reg_we;
        obs_wb_waddr = wb_reg_waddr;
        obs_wb_wdata = wb_reg_wdata;
        obs_pulses  += int'(wb_valid);
    endtask

    task automatic run_mem(input int op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] waddr, input logic we, input logic [31:0] alu,
                           input int gd, input int rd, input logic [31:0] rdata);
        valid = 1'b1; mem_op = 4'(op); mem_we = (op >= 6); mem_addr = addr; mem_data = data;
        reg_waddr = waddr; reg_we = we; reg_wdata = alu;
        @(negedge clk);
        valid = 1'b0;
        obs_pulses = 0; obs_stable = 1; obs_stall_ok = 1; obs_wait_ok = 1; obs_mis = 0; obs_mis_next = 0;
        obs_ready_first = ready;
        obs_ready_after = ready;
        obs_wb_we = 1'bx; obs_wb_waddr = 'x; obs_wb_wdata = 'x;
        obs_mem = dbus_req;
        obs_addr = dbus_addr; obs_be = dbus_be; obs_wdata = dbus_wdata; obs_bus_we = dbus_we;
        if (!dbus_req) begin
            capture_wb();
`ifdef MEM_MISALIGN_TRAP_EN
            obs_mis = misalign;
`endif
        end else begin
            for (int i = 0; i <= gd; i++) begin
                if (!(stall && dbus_req)) obs_stall_ok = 0;
                if (dbus_addr !== obs_addr || dbus_be !== obs_be || dbus_wdata !== obs_wdata ||
                    dbus_we !== obs_bus_we) obs_stable = 0;
                obs_pulses += int'(wb_valid);
                if (i < gd) @(negedge clk);
            end
            dbus_gnt = 1'b1;
            @(negedge clk);
            dbus_gnt = 1'b0;
            if (op >= 6) begin
                capture_wb();
            end else begin
                for (int i = 0; i < rd; i++) begin
                    if (dbus_req || !stall) obs_wait_ok = 0;
                    obs_pulses += int'(wb_valid);
                    @(negedge clk);
                end
                if (dbus_req || !stall) obs_wait_ok = 0;
                dbus_rvalid = 1'b1; dbus_rdata = rdata;
                @(negedge clk);
                dbus_rvalid = 1'b0; dbus_rdata = $urandom;
                capture_wb();
            end
            obs_ready_after = ready;
        end
        @(negedge clk);
        obs_pulses += int'(wb_valid);
`ifdef MEM_MISALIGN_TRAP_EN
        obs_mis_next = misalign;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL reset_ready: got ready=%b stall=%b want 1/0", ready, stall); end
        checks++; if ({dbus_req, dbus_we, dbus_be} !== 6'd0 || dbus_addr !== 0 || dbus_wdata !== 0) begin errors++; $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h want zeros", dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata); end
        checks++; if ({wb_valid, wb_reg_we, wb_reg_waddr} !== 7'd0 || wb_reg_wdata !== 0) begin errors++; $display("FAIL reset_wb: got v=%b we=%b wa=%0d wd=%h want zeros", wb_valid, wb_reg_we, wb_reg_waddr, wb_reg_wdata); end
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nop();
        run_mem(0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 0, 32'h0);
        checks++; if (obs_mem !== 1'b0 || obs_ready_first !== 1'b1) begin errors++; $display("FAIL nop_ready: got req=%b ready=%b want 0/1", obs_mem, obs_ready_first); end
        checks++; if (obs_pulses != 1) begin errors++; $display("FAIL nop_pulse: got %0d want 1", obs_pulses); end
        checks++; if (obs_wb_wdata !== 32'h1234 || obs_wb_waddr !== 5'd5 || obs_wb_we !== 1'b1) begin errors++; $display("FAIL nop_wb: got %h/%0d/%b want 00001234/5/1", obs_wb_wdata, obs_wb_waddr, obs_wb_we); end
    endtask

    task automatic test_store_sb();
        run_mem(6, 32'h1003, 32'hA5, 5'd7, 1'b0, 32'h0, 2, 0, 32'h0);
        checks++; if (obs_be !== 4'b1000 || obs_addr !== 32'h1000) begin errors++; $display("FAIL sb_be_addr: got be=%b addr=%h want 1000/00001000", obs_be, obs_addr); end
        checks++; if (obs_wdata !== 32'hA5A5A5A5 || obs_bus_we !== 1'b1) begin errors++; $display("FAIL sb_wdata: got %h we=%b want a5a5a5a5/1", obs_wdata, obs_bus_we); end
        checks++; if (!obs_stable || !obs_stall_ok) begin errors++; $display("FAIL sb_hold: got stable=%b stall_ok=%b want 1/1", obs_stable, obs_stall_ok); end
        checks++; if (obs_ready_after !== 1'b1 || obs_wb_we !== 1'b0 || obs_pulses != 1) begin errors++; $display("FAIL sb_wb: got ready=%b we=%b pulses=%0d want 1/0/1", obs_ready_after, obs_wb_we, obs_pulses); end
    endtask

    task automatic test_loads();
        run_mem(1, 32'h2001, 32'h0, 5'd3, 1'b1, 32'h0, 1, 0, 32'h0000_8000);
        checks++; if (obs_wb_wdata !== 32'hFFFFFF80 || obs_be !== 4'hF) begin errors++; $display("FAIL lb_ext: got %h be=%h want ffffff80/f", obs_wb_wdata, obs_be); end
        run_mem(4, 32'h2001, 32'h0, 5'd3, 1'b1, 32'h0, 0, 1, 32'h0000_8000);
        checks++; if (obs_wb_wdata !== 32'h00000080) begin errors++; $display("FAIL lbu_ext: got %h want 00000080", obs_wb_wdata); end
        run_mem(2, 32'h2002, 32'h0, 5'd9, 1'b1, 32'h0, 0, 0, 32'hBEEF_0000);
        checks++; if (obs_wb_wdata !== 32'hFFFFBEEF || obs_addr !== 32'h2000) begin errors++; $display("FAIL lh_ext: got %h addr=%h want ffffbeef/00002000", obs_wb_wdata, obs_addr); end
        run_mem(3, 32'h2004, 32'h0, 5'd11, 1'b1, 32'h0, 0, 2, 32'hCAFE_F00D);
        checks++; if (obs_wb_wdata !== 32'hCAFEF00D || obs_wb_waddr !== 5'd11 || obs_wb_we !== 1'b1) begin errors++; $display("FAIL lw_data: got %h/%0d/%b want cafef00d/11/1", obs_wb_wdata, obs_wb_waddr, obs_wb_we); end
        checks++; if (obs_pulses != 1 || !obs_wait_ok || obs_ready_after !== 1'b1) begin errors++; $display("FAIL lw_pulse: got pulses=%0d wait_ok=%b ready=%b want 1/1/1", obs_pulses, obs_wait_ok, obs_ready_after); end
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; mem_op = 4'd3; mem_we = 1'b0; mem_addr = 32'h4000; reg_waddr = 5'd4; reg_we = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: got %b want 1", dbus_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (dbus_req !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL rst_req_drop: got req=%b ready=%b want 0/1", dbus_req, ready); end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        checks++; if (dbus_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rst_waitr: got req=%b stall=%b want 0/1", dbus_req, stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (dbus_req !== 1'b0 || ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_waitr_idle: got req=%b ready=%b wbv=%b want 0/1/0", dbus_req, ready, wb_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_2222;
        @(negedge clk);
        dbus_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL rst_late_rvalid: got wbv=%b ready=%b want 0/1", wb_valid, ready); end
        run_mem(0, 32'h0, 32'h0, 5'd6, 1'b1, 32'h5555, 0, 0, 32'h0);
        checks++; if (obs_pulses != 1 || obs_wb_wdata !== 32'h5555) begin errors++; $display("FAIL rst_next_ok: got pulses=%0d wd=%h want 1/00005555", obs_pulses, obs_wb_wdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        for (int i = 0; i < 3; i++) vals[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; mem_op = 4'd0; reg_we = 1'b1; reg_waddr = 5'(i + 1); reg_wdata = vals[i];
            @(negedge clk);
            checks++; if (wb_valid !== 1'b1 || wb_reg_wdata !== vals[i] || wb_reg_waddr !== 5'(i + 1) || ready !== 1'b1) begin errors++; $display("FAIL b2b_%0d: got v=%b wd=%h wa=%0d rdy=%b want 1/%h/%0d/1", i, wb_valid, wb_reg_wdata, wb_reg_waddr, ready, vals[i], i + 1); end
        end
        valid = 1'b0;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", wb_valid); end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        run_mem(3, 32'h3002, 32'h0, 5'd8, 1'b1, 32'h0, 0, 0, 32'h0);
        checks++; if (obs_mem !== 1'b0 || obs_ready_first !== 1'b1) begin errors++; $display("FAIL mis_noreq: got req=%b ready=%b want 0/1", obs_mem, obs_ready_first); end
        checks++; if (obs_mis !== 1'b1 || obs_mis_next !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b then %b want 1 then 0", obs_mis, obs_mis_next); end
        checks++; if (obs_pulses != 1 || obs_wb_we !== 1'b0) begin errors++; $display("FAIL mis_wb: got pulses=%0d we=%b want 1/0", obs_pulses, obs_wb_we); end
    endtask
`endif

    task automatic test_random_mix();
        int op, a, gd, rd;
        logic [31:0] addr, data, rdata, alu;
        logic [4:0]  wa;
        logic        we;
        bit          exp_mem;
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 8)); addr = $urandom; data = $urandom; rdata = $urandom;
            alu = $urandom; wa = 5'($urandom); we = 1'($urandom);
            gd = int'($urandom_range(0, 3)); rd = int'($urandom_range(0, 3));
            a = int'(addr & 32'd3);
            exp_mem = (op != 0) && !m_trap(op, a);
            run_mem(op, addr, data, wa, we, alu, gd, rd, rdata);
            checks++; if (obs_mem !== exp_mem || obs_pulses != 1) begin errors++; $display("FAIL rnd%0d_flow: op=%0d got req=%b pulses=%0d want %b/1", n, op, obs_mem, obs_pulses, exp_mem); end
            if (exp_mem) begin
                checks++; if (obs_be !== m_be(op, a) || obs_addr !== (addr & ~32'd3) || obs_bus_we !== (op >= 6)) begin errors++; $display("FAIL rnd%0d_bus: op=%0d got be=%h addr=%h we=%b want %h/%h/%b", n, op, obs_be, obs_addr, obs_bus_we, m_be(op, a), addr & ~32'd3, op >= 6); end
                checks++; if (!obs_stable || !obs_stall_ok || !obs_wait_ok) begin errors++; $display("FAIL rnd%0d_hold: got stable=%b stall=%b wait=%b want 1/1/1", n, obs_stable, obs_stall_ok, obs_wait_ok); end
                if (op >= 6) begin
                    checks++; if (obs_wdata !== m_wdata(op, data) || obs_wb_we !== 1'b0) begin errors++; $display("FAIL rnd%0d_store: op=%0d got wd=%h wbwe=%b want %h/0", n, op, obs_wdata, obs_wb_we, m_wdata(op, data)); end
                end else begin
                    checks++; if (obs_wb_wdata !== m_load(op, a, rdata) || obs_wb_we !== we || obs_wb_waddr !== wa) begin errors++; $display("FAIL rnd%0d_load: op=%0d a=%0d got %h/%b/%0d want %h/%b/%0d", n, op, a, obs_wb_wdata, obs_wb_we, obs_wb_waddr, m_load(op, a, rdata), we, wa); end
                end
            end else if (op == 0) begin
                checks++; if (obs_wb_wdata !== alu || obs_wb_we !== we || obs_wb_waddr !== wa) begin errors++; $display("FAIL rnd%0d_nop: got %h/%b/%0d want %h/%b/%0d", n, obs_wb_wdata, obs_wb_we, obs_wb_waddr, alu, we, wa); end
            end else begin
                checks++; if (obs_wb_we !== 1'b0 || obs_mis !== 1'b1) begin errors++; $display("FAIL rnd%0d_trap: op=%0d got we=%b mis=%b want 0/1", n, op, obs_wb_we, obs_mis); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_store_sb();
        test_loads();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_random_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
